grey_cnt_nb: RTL and testbench
==============================

# grey_cnt_nb

Parametrised, registered N-bit counter that holds its state in natural binary (NKB) and presents both the binary count and its Gray-code image every cycle. It is the clocked successor to the 4-bit NKB-to-Gray converter. It adds:
- width generalisation,
- count enable,
- synchronous load of a Gray-coded value,
- a wrap pulse,
- an optional count direction.

It sits in the Gray-counter design as the state source for displays and pointer logic that need single-bit-change sequences.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; one step per clock while high
- load  in  1  synchronous load strobe
- load_gray  in  WIDTH  Gray-coded value to load
- dir  in  1  1 = up, 0 = down; present only with GREY_CNT_DOWN_EN
- bin  out  WIDTH  registered binary count
- gray  out  WIDTH  registered Gray image of bin
- wrap  out  1  registered one-cycle pulse on roll-over

## Operation
- Reset (rst_n low):
  - bin = 0, gray = 0, wrap = 0.
  - Applied asynchronously, mid-count included.
  - Takes effect immediately, with no clock edge required.
- Release: the first active edge after rst_n rises may count or load normally.
- Priority per edge: load > en > hold.
- Load:
  - load_gray is converted to binary as b[WIDTH-1] = g[WIDTH-1], b[i] = b[i+1] ^ g[i].
  - The result is written to bin.
  - gray takes the re-encoded value, equal to load_gray.
  - wrap = 0 on a load edge, regardless of en.
- Count up: bin_next = bin + 1, modulo 2^WIDTH.
- Count down (macro only): bin_next = bin - 1, modulo 2^WIDTH.
- Gray encode:
  - gray_next[i] = bin_next[i] ^ bin_next[i+1].
  - gray_next[WIDTH-1] = bin_next[WIDTH-1].
  - gray is a flop, never combinational from bin, so its output is glitch-free.
- Wrap:
  - Up: wrap = 1 on the edge where bin goes from 2^WIDTH-1 to 0.
  - Down: wrap = 1 on the edge where bin goes from 0 to 2^WIDTH-1.
  - Otherwise 0.
- Hold: with en = 0 and load = 0, bin and gray are unchanged and wrap = 0.
- Invariant: consecutive gray values during counting differ in exactly one bit. Loads are exempt.

## Timing
- Latency: one clock from en, load or dir sampled to bin, gray and wrap updated.
- All three outputs change on the same edge and are mutually consistent every cycle.
- wrap is high for exactly one cycle per roll-over. With en held high, it repeats every 2^WIDTH cycles.
- Changing dir on the same edge as a step: the step uses the newly sampled dir.
- load with en high: the loaded value wins and no increment is applied that cycle.

## Configuration
- GREY_CNT_DOWN_EN defined:
  - The dir port exists.
  - Down-counting and down-wrap detection are built.
- Not defined:
  - No dir port; the counter is up-only.
  - Only up-wrap detection is built.

## Structure
- Shared package grey_pkg:
  - constants GREY_WMIN = 2 and GREY_WMAX = 16;
  - function nkb2grey (parametrised on WIDTH);
  - function grey2nkb (parametrised on WIDTH).
- Sub-module nkb_grey_conv: combinational, WIDTH-parametrised NKB-to-Gray encoder, instanced once on bin_next.
- Gray-to-binary decoding for load is done inline via grey2nkb.

## Test plan
- Reset and count up (WIDTH = 4): release rst_n, hold en = 1 for 4 cycles → gray goes 0000, 0001, 0011, 0010, 0110; bin goes 0, 1, 2, 3, 4.
- Wrap: load_gray = 1000 (bin 15), then en = 1 for one cycle → bin = 0, gray = 0000, wrap = 1 for that cycle only. Then 15 further counts → wrap = 0 throughout.
- Load priority: en = 1, load = 1, load_gray = 0101 → bin = 6, gray = 0101, wrap = 0, with no increment.
- Down (macro on): bin = 0, dir = 0, en = 1 → bin = 15, gray = 1000, wrap = 1. Next edge → bin = 14, gray = 1001, wrap = 0.
- Async reset mid-count: drop rst_n between edges at bin = 9 → bin, gray and wrap are 0 before the next clock edge.
- Full-sequence check (WIDTH = 8, en = 1, 512 cycles): gray Hamming distance between consecutive values is 1, and gray equals nkb2grey(bin) every cycle.

Source files
------------

// File: rtl/grey_pkg.sv
// grey_pkg: shared constants and NKB <-> Gray helper functions for the
// Gray-counter design.
//
// Contents:
//   GREY_WMIN / GREY_WMAX  legal counter width range (2..16)
//   nkb2grey(b)            natural binary to Gray code
//   grey2nkb(g)            Gray code to natural binary
//
// Both functions work on GREY_WMAX-bit vectors. A WIDTH-bit operand is
// zero-extended on the way in and truncated on the way out. The zero upper
// bits do not disturb either transform, so one function serves every WIDTH.
package grey_pkg;

  localparam int GREY_WMIN = 2;
  localparam int GREY_WMAX = 16;

  // g[i] = b[i] ^ b[i+1], and the top bit passes through unchanged.
  function automatic logic [GREY_WMAX-1:0] nkb2grey(input logic [GREY_WMAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // b[i] = b[i+1] ^ g[i], so each binary bit is the XOR of all Gray bits
  // at or above it. Walk down from the MSB.
  function automatic logic [GREY_WMAX-1:0] grey2nkb(input logic [GREY_WMAX-1:0] g);
    logic [GREY_WMAX-1:0] b;
    b[GREY_WMAX-1] = g[GREY_WMAX-1];
    for (int i = GREY_WMAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/nkb_grey_conv.sv
// nkb_grey_conv: combinational WIDTH-bit natural-binary to Gray encoder.
//
// Ports:
//   bin   in  WIDTH  natural binary value
//   gray  out WIDTH  Gray image: gray[i] = bin[i] ^ bin[i+1], MSB passes through
module nkb_grey_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/grey_cnt_nb.sv
// grey_cnt_nb: registered N-bit counter. The state is held in natural binary.
// The counter presents the binary count and its Gray image every cycle.
//
// Parameters:
//   WIDTH      counter width in bits; legal range 2..16
//              (GREY_WMIN..GREY_WMAX in grey_pkg)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      count enable; one step per clock while high
//   load       in   1      synchronous load strobe; takes priority over en
//   load_gray  in   WIDTH  Gray-coded value to load
//   dir        in   1      1 = up, 0 = down (only with GREY_CNT_DOWN_EN)
//   bin        out  WIDTH  registered binary count
//   gray       out  WIDTH  registered Gray image of bin
//   wrap       out  1      registered one-cycle pulse on roll-over
//
// Build option:
//   GREY_CNT_DOWN_EN  adds the dir port, down-counting and down-wrap detection.
//                     When it is undefined, the counter is up-only.
module grey_cnt_nb
  import grey_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
`ifdef GREY_CNT_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] load_bin;
  logic             wrap_next;

  // Decode the Gray load value. The helper works on the widest vector,
  // so the operand is zero-extended going in and truncated coming out.
  assign load_bin = WIDTH'(grey2nkb(GREY_WMAX'(load_gray)));

  // Next-state selection. A load overrides counting and never signals a
  // wrap. A step signals a wrap only when it crosses the all-ones/zero
  // boundary in its own direction.
  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
`ifdef GREY_CNT_DOWN_EN
      if (dir) begin
        bin_next  = bin + 1'b1;
        wrap_next = (bin == {WIDTH{1'b1}});
      end else begin
        bin_next  = bin - 1'b1;
        wrap_next = (bin == {WIDTH{1'b0}});
      end
`else
      bin_next  = bin + 1'b1;
      wrap_next = (bin == {WIDTH{1'b1}});
`endif
    end
  end

  // Encode the next value rather than the current one. Gray can then be
  // registered on the same edge as bin: it stays in step with bin and is
  // glitch-free. After a load this re-encoding reproduces load_gray exactly.
  nkb_grey_conv #(
    .WIDTH(WIDTH)
  ) u_conv (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Output registers. All three outputs update together, so they are
  // mutually consistent every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_grey_cnt_nb.sv
// tb_grey_cnt_nb: scoreboard bench for grey_cnt_nb.
//
// u_dut  (WIDTH = 4) runs the directed vectors: reset, count up, wrap, hold,
//        load priority, asynchronous reset mid-count, and down counting when
//        GREY_CNT_DOWN_EN is defined.
// u_dut8 (WIDTH = 8) counts freely for 512 cycles. Each step is checked
//        against an independent count, its Gray image and single-bit change.
module tb_grey_cnt_nb;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       w;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [3:0] load_gray;
  logic       dir;
  logic [3:0] bin;
  logic [3:0] gray;
  logic       wrap;

  logic       rst8_n;
  logic       en8;
  logic       load8;
  logic [7:0] load_gray8;
  logic       dir8;
  logic [7:0] bin8;
  logic [7:0] gray8;
  logic       wrap8;

  exp_t       sb[$];
  logic [7:0] sb8[$];
  int         n_cmp;
  int         n_bad;
  bit         done8;
  event       async_evt;

  grey_cnt_nb #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_gray (load_gray),
`ifdef GREY_CNT_DOWN_EN
    .dir       (dir),
`endif
    .bin       (bin),
    .gray      (gray),
    .wrap      (wrap)
  );

  grey_cnt_nb #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst8_n),
    .en        (en8),
    .load      (load8),
    .load_gray (load_gray8),
`ifdef GREY_CNT_DOWN_EN
    .dir       (dir8),
`endif
    .bin       (bin8),
    .gray      (gray8),
    .wrap      (wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_output(input exp_t e);
    n_cmp += 3;
    if (bin !== e.b) begin
      n_bad++;
      $display("[TB] FAIL %s bin: got %0d expected %0d", e.name, bin, e.b);
    end
    if (gray !== e.g) begin
      n_bad++;
      $display("[TB] FAIL %s gray: got %b expected %b", e.name, gray, e.g);
    end
    if (wrap !== e.w) begin
      n_bad++;
      $display("[TB] FAIL %s wrap: got %b expected %b", e.name, wrap, e.w);
    end
  endtask

  // Drive one cycle of inputs at the falling edge. Queue the state the DUT
  // should show after the next rising edge.
  task automatic apply_stimulus(input logic en_i, input logic load_i,
                                input logic [3:0] lg_i, input logic dir_i,
                                input logic [3:0] eb, input logic [3:0] eg,
                                input logic ew, input string nm);
    exp_t e;
    @(negedge clk);
    en        = en_i;
    load      = load_i;
    load_gray = lg_i;
    dir       = dir_i;
    e.b = eb; e.g = eg; e.w = ew; e.name = nm;
    sb.push_back(e);
  endtask

  // Queue an expected reset state, then wake the monitor between clock
  // edges, so the async reset is seen without a clock edge.
  task automatic expect_async_zero(input string nm);
    exp_t e;
    e.b = 4'd0; e.g = 4'd0; e.w = 1'b0; e.name = nm;
    sb.push_back(e);
    rst_n = 1'b0;
    -> async_evt;
  endtask

  // Monitor for the 4-bit DUT. Runs one check per rising edge, or per
  // async event, while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_evt);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  // Driver for the 8-bit DUT: a free run of 512 enabled cycles.
  initial begin
    rst8_n = 1'b0; en8 = 1'b0; load8 = 1'b0; load_gray8 = 8'd0; dir8 = 1'b1;
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    for (int i = 1; i <= 512; i++) begin
      @(negedge clk);
      en8 = 1'b1;
      sb8.push_back(8'(i));
    end
    @(negedge clk);
    en8 = 1'b0;
  end

  // Monitor for the 8-bit DUT.
  initial begin
    logic [7:0] exp_b;
    logic [7:0] prev_g;
    bit         have_prev;
    int         seen;
    have_prev = 1'b0;
    seen = 0;
    done8 = 1'b0;
    while (seen < 512) begin
      @(posedge clk);
      #1;
      if (sb8.size() > 0) begin
        exp_b = sb8.pop_front();
        seen++;
        n_cmp += 3;
        if (bin8 !== exp_b) begin
          n_bad++;
          $display("[TB] FAIL w8 bin step %0d: got %0d expected %0d", seen, bin8, exp_b);
        end
        if (gray8 !== (exp_b ^ (exp_b >> 1))) begin
          n_bad++;
          $display("[TB] FAIL w8 gray step %0d: got %b expected %b", seen, gray8, exp_b ^ (exp_b >> 1));
        end
        if (wrap8 !== (exp_b == 8'd0)) begin
          n_bad++;
          $display("[TB] FAIL w8 wrap step %0d: got %b expected %b", seen, wrap8, exp_b == 8'd0);
        end
        if (have_prev) begin
          n_cmp++;
          if ($countones(gray8 ^ prev_g) != 1) begin
            n_bad++;
            $display("[TB] FAIL w8 hamming step %0d: got %0d expected 1", seen, $countones(gray8 ^ prev_g));
          end
        end
        prev_g = gray8;
        have_prev = 1'b1;
      end
    end
    done8 = 1'b1;
  end

  // Directed sequence for the 4-bit DUT.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_gray = 4'd0; dir = 1'b1;

    #3;
    expect_async_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up from reset.
    apply_stimulus(1, 0, 4'b0000, 1, 4'd1, 4'b0001, 0, "up1");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd2, 4'b0011, 0, "up2");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd3, 4'b0010, 0, "up3");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd4, 4'b0110, 0, "up4");

    // Load 15, then wrap, then a full lap with no wrap.
    apply_stimulus(0, 1, 4'b1000, 1, 4'd15, 4'b1000, 0, "load15");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd0,  4'b0000, 1, "wrap_up");
    for (int k = 1; k <= 15; k++) begin
      apply_stimulus(1, 0, 4'b0000, 1, 4'(k), g4(4'(k)), 0, "lap");
    end

    // Hold at 15, then wrap again.
    apply_stimulus(0, 0, 4'b0000, 1, 4'd15, 4'b1000, 0, "hold");
    apply_stimulus(0, 0, 4'b0000, 1, 4'd15, 4'b1000, 0, "hold2");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd0,  4'b0000, 1, "wrap_again");

    // Load beats en. A load at 15 with en high does not wrap.
    apply_stimulus(1, 1, 4'b0101, 1, 4'd6,  4'b0101, 0, "load_pri");
    apply_stimulus(0, 1, 4'b1000, 1, 4'd15, 4'b1000, 0, "load15b");
    apply_stimulus(1, 1, 4'b0011, 1, 4'd2,  4'b0011, 0, "load_at_top");

    // Count to 9, then assert reset between edges.
    for (int k = 3; k <= 9; k++) begin
      apply_stimulus(1, 0, 4'b0000, 1, 4'(k), g4(4'(k)), 0, "to9");
    end
    @(posedge clk);
    #3;
    expect_async_zero("async_rst");
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 0, 4'b0000, 1, 4'd1, 4'b0001, 0, "post_rst");

`ifdef GREY_CNT_DOWN_EN
    apply_stimulus(0, 1, 4'b0000, 1, 4'd0,  4'b0000, 0, "load0");
    apply_stimulus(1, 0, 4'b0000, 0, 4'd15, 4'b1000, 1, "wrap_dn");
    apply_stimulus(1, 0, 4'b0000, 0, 4'd14, 4'b1001, 0, "dn14");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd15, 4'b1000, 0, "dir_up");
    apply_stimulus(1, 0, 4'b0000, 1, 4'd0,  4'b0000, 1, "dir_wrap");
`endif

    @(negedge clk);
    en = 1'b0;
    load = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    for (int i = 0; i < 2000 && !done8; i++) @(posedge clk);
    #2;
    if (!done8) begin
      n_bad++;
      $display("[TB] FAIL w8_timeout: got done=0 expected done=1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
